// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Steps through a small note table of (scale_factor, duration)
//                entries and drives the shared clock_scale divider's
//                scale_factor and reset inputs for tone playback.
//                A scale_factor of 0 is a rest (divider held in reset); a
//                duration of 0 marks the end of the sequence.
//
//  Ports
//    clk          in  system clock
//    rst          in  synchronous, active-high reset
//    wr_en        in  table write strobe
//    wr_addr      in  table write index
//    wr_sf        in  scale_factor for the entry (0 = rest)
//    wr_dur       in  duration in ticks (0 = end-of-sequence marker)
//    start        in  begin playback at entry 0 (ignored while busy)
//    stop         in  abort playback (ignored while idle)
//    loop_en      in  wrap to entry 0 after the last entry
//    scale_factor out divider scale_factor
//    div_rst      out divider reset (high = divider held, output low)
//    busy         out high whenever not idle
//    step_idx     out index of the entry being played
//    done         out 1-cycle pulse when the sequence ends or is stopped
//
//  Build option
//    TONE_SEQ_GAP_EN : when defined, every note-to-note advance (including
//                      the loop wrap) passes through a one-tick silent GAP.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tone_sequencer #(
    parameter int DEPTH    = 8,
    parameter int SF_W     = 11,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SF_W-1:0]          wr_sf,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [SF_W-1:0]          scale_factor,
    output logic                     div_rst,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     done
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = $clog2(TICK_DIV);

    localparam logic [c_PW-1:0]  c_PS_LAST  = c_PW'(TICK_DIV - 1);
    localparam logic [c_AW-1:0]  c_IDX_LAST = c_AW'(DEPTH - 1);
    localparam logic [c_AW-1:0]  c_IDX_ONE  = c_AW'(1);
    localparam logic [DUR_W-1:0] c_DUR_ONE  = DUR_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_PLAY = 2'd2;
`ifdef TONE_SEQ_GAP_EN
    localparam logic [1:0] c_ST_GAP  = 2'd3;
`endif

    // ------------------------------------------------------------------------
    // Note table: not reset, writable in any state. The playing entry is only
    // sampled in LOAD, so a rewrite takes effect on the entry's next play.
    // ------------------------------------------------------------------------
    logic [SF_W+DUR_W-1:0] r_table [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= {wr_sf, wr_dur};
        end
    end

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [SF_W-1:0]  r_sf;
    logic             r_div_rst;
    logic             r_busy;
    logic [c_AW-1:0]  r_step_idx;
    logic             r_done;
    logic [c_PW-1:0]  r_prescaler;
    logic [DUR_W-1:0] r_dur_cnt;

    logic [1:0]       w_state_nxt;
    logic [SF_W-1:0]  w_sf_nxt;
    logic             w_div_rst_nxt;
    logic             w_busy_nxt;
    logic [c_AW-1:0]  w_idx_nxt;
    logic             w_done_nxt;
    logic [c_PW-1:0]  w_ps_nxt;
    logic [DUR_W-1:0] w_dur_nxt;

    logic [SF_W+DUR_W-1:0] w_entry;
    logic [SF_W-1:0]       w_entry_sf;
    logic [DUR_W-1:0]      w_entry_dur;
    logic                  w_tick;

    assign w_entry     = r_table[r_step_idx];
    assign w_entry_sf  = w_entry[SF_W+DUR_W-1:DUR_W];
    assign w_entry_dur = w_entry[DUR_W-1:0];
    assign w_tick      = (r_prescaler == c_PS_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_sf_nxt    = r_sf;
        w_idx_nxt   = r_step_idx;
        w_ps_nxt    = r_prescaler;
        w_dur_nxt   = r_dur_cnt;
        w_done_nxt  = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_LOAD;
                    w_idx_nxt   = '0;
                end
            end

            c_ST_LOAD: begin
                if (stop || (w_entry_dur == '0)) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = c_ST_PLAY;
                    w_sf_nxt    = w_entry_sf;
                    w_dur_nxt   = w_entry_dur;
                    w_ps_nxt    = '0;
                end
            end

            c_ST_PLAY: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ps_nxt = w_tick ? '0 : r_prescaler + 1'b1;
                    if (w_tick) begin
                        w_dur_nxt = r_dur_cnt - c_DUR_ONE;
                        if (r_dur_cnt == c_DUR_ONE) begin
                            if ((r_step_idx != c_IDX_LAST) || loop_en) begin
`ifdef TONE_SEQ_GAP_EN
                                w_state_nxt = c_ST_GAP;
`else
                                // Index wraps to 0 naturally: DEPTH is a power of 2.
                                w_state_nxt = c_ST_LOAD;
                                w_idx_nxt   = r_step_idx + c_IDX_ONE;
`endif
                            end else begin
                                w_state_nxt = c_ST_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end
                end
            end

`ifdef TONE_SEQ_GAP_EN
            // One silent tick; the index advances on the way out so step_idx
            // keeps naming the note that just finished.
            c_ST_GAP: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ps_nxt = w_tick ? '0 : r_prescaler + 1'b1;
                    if (w_tick) begin
                        w_state_nxt = c_ST_LOAD;
                        w_idx_nxt   = r_step_idx + c_IDX_ONE;
                    end
                end
            end
`endif

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Divider outputs follow the state being entered so that every output
        // is a plain register: silent everywhere except PLAY of a non-rest note.
        if (w_state_nxt == c_ST_IDLE) begin
            w_sf_nxt = '0;
        end
        w_div_rst_nxt = (w_state_nxt == c_ST_PLAY) ? (w_sf_nxt == '0) : 1'b1;
        w_busy_nxt    = (w_state_nxt != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sf        <= '0;
            r_div_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_step_idx  <= '0;
            r_done      <= 1'b0;
            r_prescaler <= '0;
            r_dur_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sf        <= w_sf_nxt;
            r_div_rst   <= w_div_rst_nxt;
            r_busy      <= w_busy_nxt;
            r_step_idx  <= w_idx_nxt;
            r_done      <= w_done_nxt;
            r_prescaler <= w_ps_nxt;
            r_dur_cnt   <= w_dur_nxt;
        end
    end

    assign scale_factor = r_sf;
    assign div_rst      = r_div_rst;
    assign busy         = r_busy;
    assign step_idx     = r_step_idx;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_sequencer
//  Description : Directed self-checking bench for tone_sequencer with
//                DEPTH=4, TICK_DIV=4. Cycle index k counts from the first
//                LOAD cycle (k=0); expected values are hand-derived tables.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tone_sequencer;

    localparam int c_DEPTH = 4;
    localparam int c_SF_W  = 11;
    localparam int c_DUR_W = 8;
    localparam int c_TICK  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_addr = '0;
    logic [c_SF_W-1:0] wr_sf = '0;
    logic [c_DUR_W-1:0] wr_dur = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [c_SF_W-1:0] scale_factor;
    logic              div_rst;
    logic              busy;
    logic [1:0]        step_idx;
    logic              done;

    int checks   = 0;
    int failures = 0;

    tone_sequencer #(
        .DEPTH    (c_DEPTH),
        .SF_W     (c_SF_W),
        .DUR_W    (c_DUR_W),
        .TICK_DIV (c_TICK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_sf        (wr_sf),
        .wr_dur       (wr_dur),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .scale_factor (scale_factor),
        .div_rst      (div_rst),
        .busy         (busy),
        .step_idx     (step_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int sf, input int dur);
        wr_en   = 1'b1;
        wr_addr = 2'(addr);
        wr_sf   = c_SF_W'(sf);
        wr_dur  = c_DUR_W'(dur);
        tick();
        wr_en   = 1'b0;
    endtask

    // After this returns the DUT is in the first LOAD cycle (k=0).
    task automatic start_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (div_rst !== 1'b1) begin failures++; $display("FAIL reset_div_rst got=%b exp=1", div_rst); end
        checks++; if (scale_factor !== '0) begin failures++; $display("FAIL reset_sf got=%0d exp=0", scale_factor); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (step_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", step_idx); end
        rst = 1'b0;
        tick();
        // stop while idle must not produce done
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_stop done=%b busy=%b exp done=0 busy=0", done, busy); end
    endtask

    task automatic test_reset_mid();
        loop_en = 1'b1;
        start_seq();
        repeat (7) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_busy_done busy=%b done=%b exp 0 0", busy, done); end
        checks++; if (scale_factor !== '0 || div_rst !== 1'b1) begin failures++; $display("FAIL rstmid_div sf=%0d div_rst=%b exp 0 1", scale_factor, div_rst); end
        checks++; if (step_idx !== 2'd0) begin failures++; $display("FAIL rstmid_idx got=%0d exp=0", step_idx); end
        loop_en = 1'b0;
        tick();
    endtask

`ifndef TONE_SEQ_GAP_EN
    // Table {(5,2),(9,1),(0,0),x}: sf=5 for k=1..9, sf=9 for k=10..14, done at k=15.
    task automatic test_basic();
        logic [c_SF_W-1:0] exp_sf;
        loop_en = 1'b0;
        write_entry(0, 5, 2);
        write_entry(1, 9, 1);
        write_entry(2, 0, 0);
        write_entry(3, 123, 7);
        start_seq();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick();
            exp_sf = (k == 0) ? 11'd0 : (k <= 9) ? 11'd5 : (k <= 14) ? 11'd9 : 11'd0;
            checks++; if (scale_factor !== exp_sf) begin failures++; $display("FAIL basic_sf k=%0d got=%0d exp=%0d", k, scale_factor, exp_sf); end
            checks++; if (done !== (k == 15)) begin failures++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, (k == 15)); end
            checks++; if (busy !== (k <= 14)) begin failures++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy, (k <= 14)); end
        end
    endtask

    // Table {(3,1),(0,1),(7,1),(2,1)} looping: 5 cycles per note, rest at idx1.
    task automatic test_loop();
        logic [1:0]        exp_idx;
        logic [c_SF_W-1:0] exp_sf;
        logic              exp_div;
        int                note;
        loop_en = 1'b1;
        write_entry(0, 3, 1);
        write_entry(1, 0, 1);
        write_entry(2, 7, 1);
        write_entry(3, 2, 1);
        start_seq();
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) tick();
            exp_idx = 2'((k / 5) % 4);
            note    = (k == 0) ? -1 : ((k - 1) / 5) % 4;
            case (note)
                0:       exp_sf = 11'd3;
                1:       exp_sf = 11'd0;
                2:       exp_sf = 11'd7;
                3:       exp_sf = 11'd2;
                default: exp_sf = 11'd0;
            endcase
            exp_div = ((k % 5) == 0) || (exp_idx == 2'd1);
            checks++; if (step_idx !== exp_idx) begin failures++; $display("FAIL loop_idx k=%0d got=%0d exp=%0d", k, step_idx, exp_idx); end
            checks++; if (scale_factor !== exp_sf) begin failures++; $display("FAIL loop_sf k=%0d got=%0d exp=%0d", k, scale_factor, exp_sf); end
            checks++; if (div_rst !== exp_div) begin failures++; $display("FAIL loop_div_rst k=%0d got=%b exp=%b", k, div_rst, exp_div); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL loop_done k=%0d got=%b exp=0", k, done); end
        end
        go_idle();
    endtask

    // Same looping table; stop+start together at k=12 (PLAY of idx2).
    task automatic test_stop();
        start_seq();
        repeat (12) tick();
        checks++; if (step_idx !== 2'd2 || busy !== 1'b1) begin failures++; $display("FAIL stop_pre idx=%0d busy=%b exp 2 1", step_idx, busy); end
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stop_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
        checks++; if (step_idx !== 2'd2) begin failures++; $display("FAIL stop_idx got=%0d exp=2", step_idx); end
        checks++; if (div_rst !== 1'b1 || scale_factor !== '0) begin failures++; $display("FAIL stop_div div_rst=%b sf=%0d exp 1 0", div_rst, scale_factor); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_after done=%b busy=%b exp 0 0", done, busy); end
        loop_en = 1'b0;
    endtask

    // Table {(1,1),(9,3),(2,1),(3,1)} looping; entry1 rewritten to (4,1) at k=7.
    task automatic test_rewrite();
        logic [1:0]        exp_idx;
        logic [c_SF_W-1:0] exp_sf;
        loop_en = 1'b1;
        write_entry(0, 1, 1);
        write_entry(1, 9, 3);
        write_entry(2, 2, 1);
        write_entry(3, 3, 1);
        start_seq();
        for (int k = 0; k <= 38; k++) begin
            if (k > 0) tick();
            if (k == 8) wr_en = 1'b0;
            exp_sf  = (k == 0)  ? 11'd0 : (k <= 5)  ? 11'd1 : (k <= 18) ? 11'd9 :
                      (k <= 23) ? 11'd2 : (k <= 28) ? 11'd3 : (k <= 33) ? 11'd1 : 11'd4;
            exp_idx = (k <= 4)  ? 2'd0  : (k <= 17) ? 2'd1  : (k <= 22) ? 2'd2 :
                      (k <= 27) ? 2'd3  : (k <= 32) ? 2'd0  : (k <= 37) ? 2'd1 : 2'd2;
            checks++; if (scale_factor !== exp_sf) begin failures++; $display("FAIL rewrite_sf k=%0d got=%0d exp=%0d", k, scale_factor, exp_sf); end
            checks++; if (step_idx !== exp_idx) begin failures++; $display("FAIL rewrite_idx k=%0d got=%0d exp=%0d", k, step_idx, exp_idx); end
            if (k == 7) begin
                wr_en = 1'b1; wr_addr = 2'd1; wr_sf = 11'd4; wr_dur = 8'd1;
            end
        end
        go_idle();
        loop_en = 1'b0;
    endtask

    // Table {(1,1),(2,1),(3,1),(4,1)} without loop: done after the last entry.
    task automatic test_end_of_table();
        loop_en = 1'b0;
        write_entry(0, 1, 1);
        write_entry(1, 2, 1);
        write_entry(2, 3, 1);
        write_entry(3, 4, 1);
        start_seq();
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) tick();
            checks++; if (done !== (k == 20)) begin failures++; $display("FAIL eot_done k=%0d got=%b exp=%b", k, done, (k == 20)); end
            checks++; if (busy !== (k < 20)) begin failures++; $display("FAIL eot_busy k=%0d got=%b exp=%b", k, busy, (k < 20)); end
            if (k == 20) begin
                checks++; if (step_idx !== 2'd3) begin failures++; $display("FAIL eot_idx got=%0d exp=3", step_idx); end
                checks++; if (scale_factor !== '0 || div_rst !== 1'b1) begin failures++; $display("FAIL eot_div sf=%0d div_rst=%b exp 0 1", scale_factor, div_rst); end
            end
        end
    endtask
`else
    // Table {(5,1),(6,1),(0,0)}: PLAY 4, GAP 4 between notes, done at k=19.
    task automatic test_gap();
        logic [c_SF_W-1:0] exp_sf;
        logic [1:0]        exp_idx;
        logic              exp_div;
        loop_en = 1'b0;
        write_entry(0, 5, 1);
        write_entry(1, 6, 1);
        write_entry(2, 0, 0);
        write_entry(3, 1, 1);
        start_seq();
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            exp_sf  = (k == 0) ? 11'd0 : (k <= 9) ? 11'd5 : (k <= 18) ? 11'd6 : 11'd0;
            exp_idx = (k <= 8) ? 2'd0 : (k <= 17) ? 2'd1 : 2'd2;
            exp_div = !(((k >= 1) && (k <= 4)) || ((k >= 10) && (k <= 13)));
            checks++; if (scale_factor !== exp_sf) begin failures++; $display("FAIL gap_sf k=%0d got=%0d exp=%0d", k, scale_factor, exp_sf); end
            checks++; if (step_idx !== exp_idx) begin failures++; $display("FAIL gap_idx k=%0d got=%0d exp=%0d", k, step_idx, exp_idx); end
            checks++; if (div_rst !== exp_div) begin failures++; $display("FAIL gap_div_rst k=%0d got=%b exp=%b", k, div_rst, exp_div); end
            checks++; if (done !== (k == 19)) begin failures++; $display("FAIL gap_done k=%0d got=%b exp=%b", k, done, (k == 19)); end
        end
        // stop in the middle of a GAP (k=6)
        start_seq();
        repeat (6) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL gapstop done=%b busy=%b exp 1 0", done, busy); end
        checks++; if (step_idx !== 2'd0 || scale_factor !== '0 || div_rst !== 1'b1) begin failures++; $display("FAIL gapstop_out idx=%0d sf=%0d div_rst=%b exp 0 0 1", step_idx, scale_factor, div_rst); end
        tick();
    endtask
`endif

    initial begin
        #1;
        test_reset();
`ifndef TONE_SEQ_GAP_EN
        test_basic();
        test_loop();
        test_stop();
        test_rewrite();
        test_end_of_table();
`else
        test_gap();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
